duty_ramp_arbiter: RTL and testbench

DUTY_RAMP_ARBITER -- requirements
Module: duty_ramp_arbiter

---
 rtl/duty_ramp_arbiter.sv | 137 +++++++++++++
 tb/tb_duty_ramp_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_ramp_arbiter.sv
// duty_ramp_arbiter
// Two-channel PWM duty ramp controller. Each channel accumulates up/down step
// requests in a saturating signed pending counter. At each PWM period boundary
// (trigger == 7) one shared update slot is handed to at most one channel, using
// round-robin between them when both have pending steps. The granted channel
// moves its duty one step toward the sign of its pending count, so the new duty
// is visible from trigger == 0 onward.
//
// Ports:
//   clk              system clock, all state on rising edge
//   rst              synchronous active-high reset
//   l_up, l_dn       left channel step requests (one-cycle pulses)
//   r_up, r_dn       right channel step requests (one-cycle pulses)
//   trigger[2:0]     free-running PWM period count
//   lcontrol[2:0]    left duty level (registered)
//   rcontrol[2:0]    right duty level (registered)
//   grant_l, grant_r slot consumed by that channel in this boundary cycle
//   busy             either pending counter nonzero (registered)

module duty_ramp_arbiter #(
   parameter int unsigned PEND_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       l_up,
   input  logic       l_dn,
   input  logic       r_up,
   input  logic       r_dn,
   input  logic [2:0] trigger,
   output logic [2:0] lcontrol,
   output logic [2:0] rcontrol,
   output logic       grant_l,
   output logic       grant_r,
   output logic       busy
);

   // Next-pending math is done two bits wider so +/-1 around the limits
   // cannot overflow before clamping.
   localparam logic signed [PEND_W+1:0] L_MAX = (PEND_W+2)'(2**(PEND_W-1) - 1);
   localparam logic signed [PEND_W+1:0] L_MIN = -L_MAX;
   localparam logic signed [PEND_W+1:0] L_ONE = (PEND_W+2)'(1);

   logic signed [PEND_W-1:0] r_pend_l, r_pend_r;
   logic [2:0]               r_lcontrol, r_rcontrol;
   logic                     r_busy;
   logic                     r_last_l;  // 1: left granted last, 0: right

   logic                     w_bnd;
   logic                     w_l_nz, w_r_nz, w_l_pos, w_r_pos;
   logic                     w_gl, w_gr, w_l_lim, w_r_lim;
   logic signed [PEND_W-1:0] w_pend_l_d, w_pend_r_d;
   logic [2:0]               w_lcontrol_d, w_rcontrol_d;

   function automatic logic signed [PEND_W-1:0] f_next_pend(
      input logic signed [PEND_W-1:0] pend,
      input logic                     up,
      input logic                     dn,
      input logic                     grant,
      input logic                     at_limit
   );
      logic signed [PEND_W+1:0] v;
      v = {{2{pend[PEND_W-1]}}, pend};
      if (at_limit) begin
         v = '0;
      end else if (grant) begin
         // Granted channel always has nonzero pending: step toward zero.
         v = pend[PEND_W-1] ? v + L_ONE : v - L_ONE;
      end
      if (up && !dn) begin
         v = v + L_ONE;
      end else if (dn && !up) begin
         v = v - L_ONE;
      end
      if (v > L_MAX) begin
         v = L_MAX;
      end else if (v < L_MIN) begin
         v = L_MIN;
      end
      return v[PEND_W-1:0];
   endfunction

   always_comb begin
      w_bnd   = (trigger == 3'd7) && !rst;
      w_l_nz  = (r_pend_l != '0);
      w_r_nz  = (r_pend_r != '0);
      w_l_pos = w_l_nz && !r_pend_l[PEND_W-1];
      w_r_pos = w_r_nz && !r_pend_r[PEND_W-1];

      // On a tie the channel not granted last wins.
      w_gl = w_bnd && w_l_nz && (!w_r_nz || !r_last_l);
      w_gr = w_bnd && w_r_nz && (!w_l_nz || r_last_l);

      w_l_lim = w_gl && ((w_l_pos && r_lcontrol == 3'd7) || (!w_l_pos && r_lcontrol == 3'd0));
      w_r_lim = w_gr && ((w_r_pos && r_rcontrol == 3'd7) || (!w_r_pos && r_rcontrol == 3'd0));

      w_lcontrol_d = r_lcontrol;
      if (w_gl && !w_l_lim) begin
         w_lcontrol_d = w_l_pos ? r_lcontrol + 3'd1 : r_lcontrol - 3'd1;
      end
      w_rcontrol_d = r_rcontrol;
      if (w_gr && !w_r_lim) begin
         w_rcontrol_d = w_r_pos ? r_rcontrol + 3'd1 : r_rcontrol - 3'd1;
      end

      w_pend_l_d = f_next_pend(r_pend_l, l_up, l_dn, w_gl, w_l_lim);
      w_pend_r_d = f_next_pend(r_pend_r, r_up, r_dn, w_gr, w_r_lim);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_l   <= '0;
         r_pend_r   <= '0;
         r_lcontrol <= 3'd0;
         r_rcontrol <= 3'd0;
         r_busy     <= 1'b0;
         r_last_l   <= 1'b0;
      end else begin
         r_pend_l   <= w_pend_l_d;
         r_pend_r   <= w_pend_r_d;
         r_lcontrol <= w_lcontrol_d;
         r_rcontrol <= w_rcontrol_d;
         r_busy     <= (w_pend_l_d != '0) || (w_pend_r_d != '0);
         if (w_gl) begin
            r_last_l <= 1'b1;
         end else if (w_gr) begin
            r_last_l <= 1'b0;
         end
      end
   end

   assign lcontrol = r_lcontrol;
   assign rcontrol = r_rcontrol;
   assign busy     = r_busy;
   assign grant_l  = w_gl;
   assign grant_r  = w_gr;

endmodule

// File: tb/tb_duty_ramp_arbiter.sv
// Self-checking bench for duty_ramp_arbiter. Expected boundary outcomes are
// queued when stimulus is driven and popped at each boundary cycle.
module tb_duty_ramp_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0;
   logic [2:0] trigger = 3'd0;
   logic [2:0] lcontrol, rcontrol;
   logic       grant_l, grant_r, busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       gl;
      logic       gr;
      logic [2:0] lc;
      logic [2:0] rc;
      logic       bsy;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] exp_lc = 3'd0;
   logic [2:0] exp_rc = 3'd0;

   always #5 clk = ~clk;

   duty_ramp_arbiter #(.PEND_W(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .l_up     (l_up),
      .l_dn     (l_dn),
      .r_up     (r_up),
      .r_dn     (r_dn),
      .trigger  (trigger),
      .lcontrol (lcontrol),
      .rcontrol (rcontrol),
      .grant_l  (grant_l),
      .grant_r  (grant_r),
      .busy     (busy)
   );

   function automatic void push_exp(input logic gl, input logic gr, input logic [2:0] lc,
                                     input logic [2:0] rc, input logic bsy);
      exp_t e;
      e.gl = gl; e.gr = gr; e.lc = lc; e.rc = rc; e.bsy = bsy;
      sb.push_back(e);
   endfunction

   // One clock cycle: drive requests, check grants mid-cycle, check registered
   // results after the edge, then advance trigger.
   task automatic step(input logic lu, input logic ld, input logic ru, input logic rd);
      exp_t e;
      logic bnd, have;
      l_up = lu; l_dn = ld; r_up = ru; r_dn = rd;
      bnd  = (trigger == 3'd7) && !rst;
      have = 1'b0;
      @(negedge clk);
      if (bnd) begin
         if (sb.size() != 0) begin
            e = sb.pop_front();
            have = 1'b1;
         end else begin
            e.gl = 1'b0; e.gr = 1'b0; e.lc = exp_lc; e.rc = exp_rc; e.bsy = 1'b0;
         end
      end else begin
         e.gl = 1'b0; e.gr = 1'b0; e.lc = exp_lc; e.rc = exp_rc; e.bsy = 1'b0;
      end
      if (!rst) begin
         n_checks++;
         if (grant_l !== e.gl || grant_r !== e.gr) begin
            n_fail++;
            $display("FAIL grants trig=%0d: got l=%b r=%b expected l=%b r=%b",
                     trigger, grant_l, grant_r, e.gl, e.gr);
         end
      end
      @(posedge clk);
      #1;
      l_up = 1'b0; l_dn = 1'b0; r_up = 1'b0; r_dn = 1'b0;
      if (rst) begin
         sb.delete();
         exp_lc = 3'd0;
         exp_rc = 3'd0;
      end else if (bnd) begin
         n_checks++;
         if (lcontrol !== e.lc || rcontrol !== e.rc) begin
            n_fail++;
            $display("FAIL duty after boundary: got l=%0d r=%0d expected l=%0d r=%0d",
                     lcontrol, rcontrol, e.lc, e.rc);
         end
         if (have) begin
            n_checks++;
            if (busy !== e.bsy) begin
               n_fail++;
               $display("FAIL busy after boundary: got %b expected %b", busy, e.bsy);
            end
         end
         exp_lc = e.lc;
         exp_rc = e.rc;
      end
      trigger = trigger + 3'd1;
   endtask

   task automatic goto_trig(input logic [2:0] t);
      for (int n = 0; n < 8 && trigger != t; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int n = 0; n < 64 && sb.size() != 0; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected boundaries left, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b0);
      rst = 1'b0;
      trigger = 3'd0;
   endtask

   task automatic check_out(input string name, input logic [2:0] lc, input logic [2:0] rc,
                            input logic bsy);
      n_checks++;
      if (lcontrol !== lc || rcontrol !== rc || busy !== bsy) begin
         n_fail++;
         $display("FAIL %s: got l=%0d r=%0d busy=%b expected l=%0d r=%0d busy=%b",
                  name, lcontrol, rcontrol, busy, lc, rc, bsy);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_out("reset_state", 3'd0, 3'd0, 1'b0);
      n_checks++;
      if (grant_l !== 1'b0 || grant_r !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_grant: got l=%b r=%b expected 0 0", grant_l, grant_r);
      end
      // Requests were presented during reset; nothing may come of them.
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      check_out("reset_discard", 3'd0, 3'd0, 1'b0);
   endtask

   task automatic test_single_step();
      do_reset();
      goto_trig(3'd2);
      push_exp(1'b1, 1'b0, 3'd1, 3'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check_out("single_busy", 3'd0, 3'd0, 1'b1);
      drain();
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      push_exp(1'b0, 1'b1, 3'd0, 3'd1, 1'b1);
      push_exp(1'b0, 1'b1, 3'd0, 3'd2, 1'b1);
      push_exp(1'b0, 1'b1, 3'd0, 3'd3, 1'b0);
      drain();
      // No fourth step: the next boundary must be idle.
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      check_out("saturate_final", 3'd0, 3'd3, 1'b0);
   endtask

   task automatic test_round_robin();
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      push_exp(1'b1, 1'b0, 3'd1, 3'd0, 1'b1);
      push_exp(1'b0, 1'b1, 3'd1, 3'd1, 1'b1);
      push_exp(1'b1, 1'b0, 3'd2, 3'd1, 1'b1);
      push_exp(1'b0, 1'b1, 3'd2, 3'd2, 1'b0);
      drain();
      check_out("round_robin_final", 3'd2, 3'd2, 1'b0);
   endtask

   task automatic test_limit();
      logic [2:0] lc;
      do_reset();
      // Eight single ups: seven steps then a clipped one at duty 7.
      for (int k = 1; k <= 8; k++) begin
         goto_trig(3'd0);
         lc = (k > 7) ? 3'd7 : 3'(k);
         push_exp(1'b1, 1'b0, lc, 3'd0, 1'b0);
         step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      drain();
      check_out("limit_top", 3'd7, 3'd0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         goto_trig(3'd0);
         lc = (k > 7) ? 3'd0 : 3'(7 - k);
         push_exp(1'b1, 1'b0, lc, 3'd0, 1'b0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      drain();
      check_out("limit_bottom", 3'd0, 3'd0, 1'b0);
   endtask

   task automatic test_cancel_and_boundary_req();
      do_reset();
      goto_trig(3'd2);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_out("cancel", 3'd0, 3'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      goto_trig(3'd7);
      push_exp(1'b1, 1'b0, 3'd1, 3'd0, 1'b1);
      push_exp(1'b1, 1'b0, 3'd2, 3'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      drain();
   endtask

   task automatic test_reset_mid_ramp();
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         goto_trig(3'd0);
         push_exp(1'b0, 1'b1, 3'd0, 3'(k), 1'b0);
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      drain();
      goto_trig(3'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_out("pre_reset", 3'd0, 3'd5, 1'b1);
      do_reset();
      check_out("mid_reset", 3'd0, 3'd0, 1'b0);
      // Next boundary must show no grant and duties held at 0.
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      check_out("post_reset", 3'd0, 3'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_saturate();
      test_round_robin();
      test_limit();
      test_cancel_and_boundary_req();
      test_reset_mid_ramp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
